traffic_phase_ctrl: RTL and testbench

//  Actuated two-road intersection controller; successor to the fixed-cycle light sequencer.

---
 rtl/traffic_phase_ctrl.sv | 102 ++++++++++
 tb/tb_traffic_phase_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: actuated main/side intersection controller with a pedestrian WALK phase
module traffic_phase_ctrl #(
    parameter int CLK_PER_TICK = 100000000,
    parameter int T_MAIN_GREEN = 6,
    parameter int T_SIDE_GREEN = 3,
    parameter int T_YELLOW     = 1,
    parameter int T_ALLRED     = 1,
    parameter int T_WALK       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_btn,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic       walk,
    output logic [2:0] phase
);
    localparam int PW    = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int T_SW  = (T_WALK > T_SIDE_GREEN) ? T_WALK : T_SIDE_GREEN;
    localparam int T_M1  = (T_MAIN_GREEN > T_SW) ? T_MAIN_GREEN : T_SW;
    localparam int T_M2  = (T_YELLOW > T_ALLRED) ? T_YELLOW : T_ALLRED;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int TW    = $clog2(T_MAX + 1) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_TICK - 1);

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_YEL = 3'd1,
        ALLRED_A = 3'd2,
        SIDE_GRN = 3'd3,
        SIDE_YEL = 3'd4,
        ALLRED_B = 3'd5
    } state_t;

    state_t          r_state, w_nxt;
    logic [PW-1:0]   r_pre, w_pre_nxt;
    logic [TW-1:0]   r_ticks, w_ticks_nxt, w_elapsed, w_dur;
    logic            r_side_pend, r_ped_pend, r_serve_ped;
    logic            w_side_p, w_ped_p, w_serve_nxt, w_tick, w_adv, w_chg, w_entry, w_walk;
    logic [2:0]      r_l1, r_l2, w_l1, w_l2;

    // next state, timers, request latches and registered lamp values
    always_comb begin
        w_tick      = (r_pre == PRE_LAST);
        w_elapsed   = (r_ticks == '1) ? r_ticks : r_ticks + 1'b1;
        w_side_p    = r_side_pend | (side_req & (r_state != SIDE_GRN));
        w_ped_p     = r_ped_pend | (ped_btn & (r_state != SIDE_GRN));
        w_dur       = (r_state == MAIN_GRN) ? TW'(T_MAIN_GREEN) :
                      (r_state == MAIN_YEL || r_state == SIDE_YEL) ? TW'(T_YELLOW) :
                      (r_state == SIDE_GRN) ? (r_serve_ped ? TW'(T_SW) : TW'(T_SIDE_GREEN)) :
                      TW'(T_ALLRED);
        w_adv       = w_tick && (w_elapsed >= w_dur) && (r_state != MAIN_GRN || w_side_p || w_ped_p);
        w_nxt       = ALLRED_B;
        case (r_state)
            MAIN_GRN: w_nxt = w_adv ? MAIN_YEL : MAIN_GRN;
            MAIN_YEL: w_nxt = w_adv ? ALLRED_A : MAIN_YEL;
            ALLRED_A: w_nxt = w_adv ? SIDE_GRN : ALLRED_A;
            SIDE_GRN: w_nxt = w_adv ? SIDE_YEL : SIDE_GRN;
            SIDE_YEL: w_nxt = w_adv ? ALLRED_B : SIDE_YEL;
            ALLRED_B: w_nxt = w_adv ? MAIN_GRN : ALLRED_B;
            default:  w_nxt = ALLRED_B;
        endcase
        w_chg       = (w_nxt != r_state);
        w_entry     = w_chg && (w_nxt == SIDE_GRN);
        w_pre_nxt   = (w_chg || w_tick) ? '0 : r_pre + 1'b1;
        w_ticks_nxt = w_chg ? '0 : (w_tick ? w_elapsed : r_ticks);
        w_serve_nxt = w_entry ? w_ped_p : r_serve_ped;
        w_walk      = (w_nxt == SIDE_GRN) && w_serve_nxt && (w_ticks_nxt < TW'(T_WALK));
        w_l1        = (w_nxt == MAIN_GRN) ? 3'b100 : (w_nxt == MAIN_YEL) ? 3'b010 : 3'b001;
        w_l2        = (w_nxt == SIDE_GRN) ? 3'b100 : (w_nxt == SIDE_YEL) ? 3'b010 : 3'b001;
    end

    // state, counters, pending requests and lamp registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ALLRED_B;
            r_pre       <= '0;
            r_ticks     <= '0;
            r_side_pend <= 1'b0;
            r_ped_pend  <= 1'b0;
            r_serve_ped <= 1'b0;
            r_l1        <= 3'b001;
            r_l2        <= 3'b001;
            walk        <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_pre       <= w_pre_nxt;
            r_ticks     <= w_ticks_nxt;
            r_side_pend <= w_entry ? 1'b0 : w_side_p;
            r_ped_pend  <= w_entry ? 1'b0 : w_ped_p;
            r_serve_ped <= w_serve_nxt;
            r_l1        <= w_l1;
            r_l2        <= w_l2;
            walk        <= w_walk;
        end
    end

    assign light1 = r_l1;
    assign light2 = r_l2;
    assign phase  = r_state;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboard bench for the actuated intersection controller
module tb_traffic_phase_ctrl;
    logic       clk, rst, side_req, ped_btn, walk, mon_en;
    logic [2:0] light1, light2, phase;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [2:0] ph;
        logic [2:0] l1;
        logic [2:0] l2;
        logic       w;
        int         len;
    } exp_t;
    exp_t exp_q[$];

    traffic_phase_ctrl #(
        .CLK_PER_TICK(2), .T_MAIN_GREEN(3), .T_SIDE_GREEN(2),
        .T_YELLOW(1), .T_ALLRED(1), .T_WALK(3)
    ) dut (
        .clk(clk), .rst(rst), .side_req(side_req), .ped_btn(ped_btn),
        .light1(light1), .light2(light2), .walk(walk), .phase(phase)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // monitor: on every phase change pop the expected new phase and the length of the old one
    initial begin
        logic [2:0] m_prev, x1, x2;
        logic       m_walk;
        int         m_len;
        exp_t       e;
        m_prev = 3'd0; m_len = 0; m_walk = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                m_prev = phase; m_len = 0; m_walk = walk;
            end else begin
                if (phase != m_prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: phase %0d -> %0d, required no change", m_prev, phase);
                    end else begin
                        e = exp_q.pop_front();
                        if ({phase, light1, light2, walk} != {e.ph, e.l1, e.l2, e.w}) begin
                            errors++;
                            $display("FAIL seg: got ph=%0d l1=%b l2=%b walk=%b, required ph=%0d l1=%b l2=%b walk=%b",
                                     phase, light1, light2, walk, e.ph, e.l1, e.l2, e.w);
                        end
                        if (e.len != 0) begin
                            checks++;
                            if (m_len != e.len) begin
                                errors++;
                                $display("FAIL len: phase %0d lasted %0d clk, required %0d", m_prev, m_len, e.len);
                            end
                        end
                    end
                    m_prev = phase; m_len = 1; m_walk = walk;
                end else begin
                    m_len++;
                end
                x1 = (phase == 3'd0) ? 3'b100 : (phase == 3'd1) ? 3'b010 : 3'b001;
                x2 = (phase == 3'd3) ? 3'b100 : (phase == 3'd4) ? 3'b010 : 3'b001;
                checks++;
                if (!$onehot(light1) || !$onehot(light2) || (light1 != 3'b001 && light2 != 3'b001) ||
                    light1 != x1 || light2 != x2 || (walk && phase != 3'd3) || walk != m_walk) begin
                    errors++;
                    $display("FAIL lamps: ph=%0d l1=%b l2=%b walk=%b, required l1=%b l2=%b walk=%b",
                             phase, light1, light2, walk, x1, x2, m_walk && phase == 3'd3);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_phase(input logic [2:0] p, input int budget);
        int n = 0;
        while (phase != p && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (phase != p) begin
            errors++;
            $display("FAIL wait_phase: phase=%0d after %0d clk, required %0d", phase, n, p);
        end
    endtask

    task automatic push(input logic [2:0] ph, input logic [2:0] l1, input logic [2:0] l2,
                        input logic w, input int len);
        exp_q.push_back('{ph, l1, l2, w, len});
    endtask

    task automatic do_reset(input logic s);
        rst = 1; mon_en = 0; side_req = s; ped_btn = 0;
        step(2);
        chk("rst_phase", phase, 3'd5);
        chk("rst_l1", light1, 3'b001);
        chk("rst_l2", light2, 3'b001);
        chk("rst_walk", {2'b00, walk}, 3'd0);
        push(3'd0, 3'b100, 3'b001, 1'b0, 2);
        rst = 0; mon_en = 1;
    endtask

    // a full service cycle's expectations following MAIN_GRN; sgl is the SIDE_GRN length
    task automatic push_cycle(input int mgl, input logic w, input int sgl);
        push(3'd1, 3'b010, 3'b001, 1'b0, mgl);
        push(3'd2, 3'b001, 3'b001, 1'b0, 2);
        push(3'd3, 3'b001, 3'b100, w, 2);
        push(3'd4, 3'b001, 3'b010, 1'b0, sgl);
        push(3'd5, 3'b001, 3'b001, 1'b0, 2);
        push(3'd0, 3'b100, 3'b001, 1'b0, 2);
    endtask

    initial begin
        rst = 1; mon_en = 0; side_req = 0; ped_btn = 0;
        do_reset(1'b0);
        // rest in main green with no requests
        step(500);
        chk("rest_phase", phase, 3'd0);
        // one-clk pedestrian pulse during rest
        push_cycle(0, 1'b1, 6);
        ped_btn = 1; step(1); ped_btn = 0;
        wait_phase(3'd1, 1);
        wait_phase(3'd0, 30);
        step(40);
        // pedestrian held only during side green is ignored
        push_cycle(0, 1'b0, 4);
        side_req = 1; step(1); side_req = 0;
        wait_phase(3'd1, 1);
        wait_phase(3'd3, 10);
        ped_btn = 1;
        wait_phase(3'd4, 10);
        ped_btn = 0;
        wait_phase(3'd0, 10);
        step(60);
        // side request held from reset release: continuous cycling, minimum main green
        do_reset(1'b1);
        push_cycle(6, 1'b0, 4);
        push_cycle(6, 1'b0, 4);
        wait_phase(3'd3, 30);
        wait_phase(3'd5, 20);
        wait_phase(3'd3, 30);
        side_req = 0;
        wait_phase(3'd0, 20);
        step(60);
        // reset mid side green with walk, then reset again with a pending pedestrian
        push(3'd1, 3'b010, 3'b001, 1'b0, 0);
        push(3'd2, 3'b001, 3'b001, 1'b0, 2);
        push(3'd3, 3'b001, 3'b100, 1'b1, 2);
        ped_btn = 1; step(1); ped_btn = 0;
        wait_phase(3'd1, 1);
        wait_phase(3'd3, 10);
        step(2);
        push(3'd5, 3'b001, 3'b001, 1'b0, 3);
        push(3'd0, 3'b100, 3'b001, 1'b0, 4);
        rst = 1; step(1);
        rst = 0; ped_btn = 1; step(1);
        ped_btn = 0; rst = 1; step(1);
        rst = 0;
        step(80);
        chk("final_phase", phase, 3'd0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue: %0d expected changes never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
